fifo_chan_router: RTL and testbench
===================================

FIFO_CHAN_ROUTER -- requirements
Module: fifo_chan_router

Interface
REQ-001 SHALL have parameter C_M_NUM_CHANNELS, default 4, number of channel FIFOs (legal 2..32).
REQ-002 SHALL have parameter C_LEN_W, default 8, width of the burst-length fields.
REQ-003 SHALL derive localparam C_CH_W = ceil(log2(C_M_NUM_CHANNELS)), minimum 1, as the channel-index width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: ACLK  in  1  clock, all state on rising edge.
REQ-005 SHALL have port ARESETn  in  1  asynchronous active-low reset.
REQ-006 SHALL have write-path ports: w_start in 1 burst request; w_active_channel in C_CH_W target channel; w_len in C_LEN_W beats minus one; m_fifo_wr_en in 1 master write strobe.
REQ-007 SHALL have write-path ports: fifo_wr_en out C_M_NUM_CHANNELS per-channel write enable; fifo_full in C_M_NUM_CHANNELS per-channel full; m_fifo_wr_ready out 1 beat acceptable; w_busy out 1; w_done out 1 burst-complete pulse.
REQ-008 SHALL have read-path ports: r_start, r_active_channel, r_len, m_fifo_rd_en, fifo_rd_en, fifo_empty, m_fifo_rd_valid, r_busy, r_done, mirroring REQ-006/007 (empty replaces full).
REQ-009 SHALL have ports err_clr in 1 clear sticky errors; err_status out 4 sticky error flags.

Function
REQ-010 Each path SHALL be an independent FSM with states IDLE and BUSY; the paths SHALL never share state.
REQ-011 In IDLE, w_start with w_active_channel < C_M_NUM_CHANNELS SHALL latch channel, load beat counter with w_len, and enter BUSY next cycle.
REQ-012 w_start with w_active_channel >= C_M_NUM_CHANNELS SHALL be ignored (stay IDLE) and set err_status[3].
REQ-013 w_start while BUSY SHALL be ignored (latched channel and counter unchanged) and set err_status[2].
REQ-014 In BUSY, m_fifo_wr_ready SHALL equal ~fifo_full[latched channel]; combinational, zero latency.
REQ-015 In BUSY, fifo_wr_en[latched channel] SHALL equal m_fifo_wr_en & ~fifo_full[latched channel]; all other bits 0; in IDLE all bits 0.
REQ-016 Each accepted beat (fifo_wr_en bit high) SHALL decrement the counter; an accepted beat with counter == 0 SHALL return the FSM to IDLE.
REQ-017 w_done SHALL pulse high exactly one cycle, the cycle after the last accepted beat; w_busy SHALL be high exactly in BUSY.
REQ-018 A burst of w_len = N SHALL transfer exactly N+1 beats; w_len = 0 SHALL be a one-beat burst; w_len all-ones SHALL transfer 2^C_LEN_W beats without counter wrap.
REQ-019 m_fifo_wr_en high in IDLE, or in BUSY with the latched FIFO full, SHALL be dropped (no enable) and set err_status[0].
REQ-020 Read path SHALL follow REQ-011..019 with fifo_empty for fifo_full, m_fifo_rd_valid for m_fifo_wr_ready, dropped read strobes setting err_status[1]; r_start errors SHALL set bits 3/2 as for write.
REQ-021 A new start SHALL be accepted in the same cycle w_done/r_done is high (back-to-back bursts, zero idle gap).
REQ-022 err_status bits SHALL be sticky until err_clr; a set event in the same cycle as err_clr SHALL win.

Reset
REQ-023 ARESETn low SHALL asynchronously force both FSMs to IDLE, counters and latched channels to 0, fifo_wr_en, fifo_rd_en, m_fifo_wr_ready, m_fifo_rd_valid, w_busy, r_busy, w_done, r_done and err_status to 0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst with no done pulse; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-025 Macro FIFO_CHAN_ROUTER_ERR_EN defined SHALL compile in error detection and the err_status register per REQ-012/013/019/020/022.
REQ-026 Macro undefined SHALL keep err_status and err_clr ports, drive err_status constant 0, ignore err_clr; all other behaviour unchanged.

Verification
REQ-027 N=4, w_start ch=2 len=3, fifos not full, m_fifo_wr_en held high -> fifo_wr_en=4'b0100 for 4 cycles, w_done one cycle after 4th beat.
REQ-028 Same burst with fifo_full[2] high on beat 2 for 3 cycles -> m_fifo_wr_ready low, strobes dropped, err_status[0]=1, burst completes with exactly 4 beats.
REQ-029 Concurrent r_start ch=1 len=0 and w_start ch=3 len=1 -> fifo_rd_en=4'b0010 one beat, fifo_wr_en=4'b1000 two beats, independent done pulses.
REQ-030 N=3, w_start ch=3 -> ignored, w_busy stays 0, err_status=4'b1000; err_clr -> 0; with macro undefined err_status stays 0.
REQ-031 ARESETn low on beat 2 of an 8-beat read -> all outputs 0 immediately, no r_done; next r_start accepted.
REQ-032 Write burst len=0 with second w_start on its w_done cycle -> second burst accepted, no idle gap, no err_status[2].

Source files
------------

// File: rtl/fifo_chan_router.sv
// Routes one master write stream and one master read stream to a set of channel FIFOs.
// Each stream runs its own IDLE/BUSY burst FSM. A burst of length N moves N+1 beats.
// Define FIFO_CHAN_ROUTER_ERR_EN to build in the sticky error register. Without it,
// err_status reads as 0 and err_clr has no effect.
module fifo_chan_router #(
  parameter int unsigned C_M_NUM_CHANNELS = 4,
  parameter int unsigned C_LEN_W          = 8,
  localparam int unsigned C_CH_W = (C_M_NUM_CHANNELS > 2) ? $clog2(C_M_NUM_CHANNELS) : 1
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  // write path
  input  logic                        w_start,
  input  logic [C_CH_W-1:0]           w_active_channel,
  input  logic [C_LEN_W-1:0]          w_len,
  input  logic                        m_fifo_wr_en,
  output logic [C_M_NUM_CHANNELS-1:0] fifo_wr_en,
  input  logic [C_M_NUM_CHANNELS-1:0] fifo_full,
  output logic                        m_fifo_wr_ready,
  output logic                        w_busy,
  output logic                        w_done,
  // read path
  input  logic                        r_start,
  input  logic [C_CH_W-1:0]           r_active_channel,
  input  logic [C_LEN_W-1:0]          r_len,
  input  logic                        m_fifo_rd_en,
  output logic [C_M_NUM_CHANNELS-1:0] fifo_rd_en,
  input  logic [C_M_NUM_CHANNELS-1:0] fifo_empty,
  output logic                        m_fifo_rd_valid,
  output logic                        r_busy,
  output logic                        r_done,
  // sticky errors: [3] bad channel, [2] start while busy, [1] dropped read, [0] dropped write
  input  logic                        err_clr,
  output logic [3:0]                  err_status
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e               r_wr_state, r_rd_state;
  logic [C_CH_W-1:0]    r_wr_ch, r_rd_ch;
  logic [C_LEN_W-1:0]   r_wr_cnt, r_rd_cnt;
  logic                 r_wr_done, r_rd_done;

  logic w_wr_ch_ok, w_rd_ch_ok;
  logic w_wr_sel_full, w_rd_sel_empty;
  logic w_wr_beat, w_rd_beat;

  assign w_wr_ch_ok = 32'(w_active_channel) < C_M_NUM_CHANNELS;
  assign w_rd_ch_ok = 32'(r_active_channel) < C_M_NUM_CHANNELS;

  // The latched channel is always in range because out-of-range starts are never taken.
  assign w_wr_sel_full  = fifo_full[r_wr_ch];
  assign w_rd_sel_empty = fifo_empty[r_rd_ch];

  assign w_busy = (r_wr_state == StBusy);
  assign r_busy = (r_rd_state == StBusy);
  assign w_done = r_wr_done;
  assign r_done = r_rd_done;

  assign w_wr_beat = w_busy & m_fifo_wr_en & ~w_wr_sel_full;
  assign w_rd_beat = r_busy & m_fifo_rd_en & ~w_rd_sel_empty;

  // Write-side handshake and per-channel enable, combinational from the latched channel.
  always_comb begin
    fifo_wr_en      = '0;
    m_fifo_wr_ready = 1'b0;
    if (w_busy) begin
      m_fifo_wr_ready     = ~w_wr_sel_full;
      fifo_wr_en[r_wr_ch] = w_wr_beat;
    end
  end

  // Read-side handshake and per-channel enable, combinational from the latched channel.
  always_comb begin
    fifo_rd_en      = '0;
    m_fifo_rd_valid = 1'b0;
    if (r_busy) begin
      m_fifo_rd_valid     = ~w_rd_sel_empty;
      fifo_rd_en[r_rd_ch] = w_rd_beat;
    end
  end

  // Write burst FSM: counts beats down to zero, then returns to IDLE with a done pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_state <= StIdle;
      r_wr_ch    <= '0;
      r_wr_cnt   <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      unique case (r_wr_state)
        StIdle: begin
          if (w_start && w_wr_ch_ok) begin
            r_wr_ch    <= w_active_channel;
            r_wr_cnt   <= w_len;
            r_wr_state <= StBusy;
          end
        end
        StBusy: begin
          if (w_wr_beat) begin
            if (r_wr_cnt == '0) begin
              r_wr_state <= StIdle;
              r_wr_done  <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt - 1'b1;
            end
          end
        end
        default: r_wr_state <= StIdle;
      endcase
    end
  end

  // Read burst FSM: same structure as the write side, gated by channel emptiness.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rd_state <= StIdle;
      r_rd_ch    <= '0;
      r_rd_cnt   <= '0;
      r_rd_done  <= 1'b0;
    end else begin
      r_rd_done <= 1'b0;
      unique case (r_rd_state)
        StIdle: begin
          if (r_start && w_rd_ch_ok) begin
            r_rd_ch    <= r_active_channel;
            r_rd_cnt   <= r_len;
            r_rd_state <= StBusy;
          end
        end
        StBusy: begin
          if (w_rd_beat) begin
            if (r_rd_cnt == '0) begin
              r_rd_state <= StIdle;
              r_rd_done  <= 1'b1;
            end else begin
              r_rd_cnt <= r_rd_cnt - 1'b1;
            end
          end
        end
        default: r_rd_state <= StIdle;
      endcase
    end
  end

`ifdef FIFO_CHAN_ROUTER_ERR_EN
  logic [3:0] r_err;
  logic [3:0] w_err_set;

  // Error events for this cycle; a bad channel only counts when the FSM could take it.
  always_comb begin
    w_err_set    = '0;
    w_err_set[3] = (w_start & ~w_busy & ~w_wr_ch_ok) | (r_start & ~r_busy & ~w_rd_ch_ok);
    w_err_set[2] = (w_start & w_busy) | (r_start & r_busy);
    w_err_set[1] = m_fifo_rd_en & (~r_busy | w_rd_sel_empty);
    w_err_set[0] = m_fifo_wr_en & (~w_busy | w_wr_sel_full);
  end

  // Sticky flags; a new event in the clear cycle survives the clear.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_err <= '0;
    end else begin
      r_err <= (err_clr ? 4'b0000 : r_err) | w_err_set;
    end
  end

  assign err_status = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_status       = 4'b0000;
`endif

endmodule

// File: tb/tb_fifo_chan_router.sv
// Directed bench for fifo_chan_router (4-channel main instance, 3-channel side instance).
// Expected error flags are masked to zero when FIFO_CHAN_ROUTER_ERR_EN is not defined.
module tb_fifo_chan_router;

`ifdef FIFO_CHAN_ROUTER_ERR_EN
  localparam logic [3:0] ERR_MASK = 4'hF;
`else
  localparam logic [3:0] ERR_MASK = 4'h0;
`endif

  logic       ACLK;
  logic       ARESETn;
  logic       w_start;
  logic [1:0] w_active_channel;
  logic [7:0] w_len;
  logic       m_fifo_wr_en;
  logic [3:0] fifo_wr_en;
  logic [3:0] fifo_full;
  logic       m_fifo_wr_ready;
  logic       w_busy;
  logic       w_done;
  logic       r_start;
  logic [1:0] r_active_channel;
  logic [7:0] r_len;
  logic       m_fifo_rd_en;
  logic [3:0] fifo_rd_en;
  logic [3:0] fifo_empty;
  logic       m_fifo_rd_valid;
  logic       r_busy;
  logic       r_done;
  logic       err_clr;
  logic [3:0] err_status;

  // side instance with three channels
  logic       d3_w_start;
  logic [1:0] d3_w_ch;
  logic       d3_err_clr;
  logic [2:0] d3_fifo_wr_en;
  logic [2:0] d3_fifo_rd_en;
  logic       d3_wr_ready, d3_w_busy, d3_w_done;
  logic       d3_rd_valid, d3_r_busy, d3_r_done;
  logic [3:0] d3_err_status;

  int n_checks = 0;
  int n_errors = 0;

  fifo_chan_router #(.C_M_NUM_CHANNELS(4), .C_LEN_W(8)) u_dut (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .w_start          (w_start),
    .w_active_channel (w_active_channel),
    .w_len            (w_len),
    .m_fifo_wr_en     (m_fifo_wr_en),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .m_fifo_wr_ready  (m_fifo_wr_ready),
    .w_busy           (w_busy),
    .w_done           (w_done),
    .r_start          (r_start),
    .r_active_channel (r_active_channel),
    .r_len            (r_len),
    .m_fifo_rd_en     (m_fifo_rd_en),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_empty       (fifo_empty),
    .m_fifo_rd_valid  (m_fifo_rd_valid),
    .r_busy           (r_busy),
    .r_done           (r_done),
    .err_clr          (err_clr),
    .err_status       (err_status)
  );

  fifo_chan_router #(.C_M_NUM_CHANNELS(3), .C_LEN_W(8)) u_dut3 (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .w_start          (d3_w_start),
    .w_active_channel (d3_w_ch),
    .w_len            (8'd0),
    .m_fifo_wr_en     (1'b0),
    .fifo_wr_en       (d3_fifo_wr_en),
    .fifo_full        (3'b000),
    .m_fifo_wr_ready  (d3_wr_ready),
    .w_busy           (d3_w_busy),
    .w_done           (d3_w_done),
    .r_start          (1'b0),
    .r_active_channel (2'd0),
    .r_len            (8'd0),
    .m_fifo_rd_en     (1'b0),
    .fifo_rd_en       (d3_fifo_rd_en),
    .fifo_empty       (3'b000),
    .m_fifo_rd_valid  (d3_rd_valid),
    .r_busy           (d3_r_busy),
    .r_done           (d3_r_done),
    .err_clr          (d3_err_clr),
    .err_status       (d3_err_status)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %04b expected %04b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ee(input logic [3:0] v);
    return v & ERR_MASK;
  endfunction

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1;
    chk4("err_cleared", err_status, 4'b0000);
  endtask

  initial begin
    ARESETn = 1'b0;
    w_start = 1'b0; w_active_channel = 2'd0; w_len = 8'd0; m_fifo_wr_en = 1'b0;
    fifo_full = 4'b0000;
    r_start = 1'b0; r_active_channel = 2'd0; r_len = 8'd0; m_fifo_rd_en = 1'b0;
    fifo_empty = 4'b0000;
    err_clr = 1'b0;
    d3_w_start = 1'b0; d3_w_ch = 2'd0; d3_err_clr = 1'b0;

    // reset state
    #3;
    chk4("rst_wr_en", fifo_wr_en, 4'b0000);
    chk4("rst_rd_en", fifo_rd_en, 4'b0000);
    chk1("rst_wr_ready", m_fifo_wr_ready, 1'b0);
    chk1("rst_rd_valid", m_fifo_rd_valid, 1'b0);
    chk1("rst_w_busy", w_busy, 1'b0);
    chk1("rst_r_busy", r_busy, 1'b0);
    chk1("rst_w_done", w_done, 1'b0);
    chk1("rst_r_done", r_done, 1'b0);
    chk4("rst_err", err_status, 4'b0000);
    step();
    step();
    ARESETn = 1'b1;
    step();

    // basic 4-beat write burst to channel 2
    w_start = 1'b1; w_active_channel = 2'd2; w_len = 8'd3;
    #1;
    chk1("wr_idle_busy", w_busy, 1'b0);
    step();
    w_start = 1'b0; m_fifo_wr_en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk4("wr_beat_en", fifo_wr_en, 4'b0100);
      chk1("wr_beat_ready", m_fifo_wr_ready, 1'b1);
      chk1("wr_beat_busy", w_busy, 1'b1);
      chk1("wr_beat_nodone", w_done, 1'b0);
      step();
    end
    m_fifo_wr_en = 1'b0;
    #1;
    chk1("wr_done_pulse", w_done, 1'b1);
    chk1("wr_done_idle", w_busy, 1'b0);
    chk4("wr_done_en", fifo_wr_en, 4'b0000);
    chk1("wr_done_ready", m_fifo_wr_ready, 1'b0);
    chk4("wr_done_err", err_status, 4'b0000);
    step();
    chk1("wr_done_once", w_done, 1'b0);

    // same burst with channel 2 full for three cycles after beat 1
    w_start = 1'b1; w_active_channel = 2'd2; w_len = 8'd3;
    step();
    w_start = 1'b0; m_fifo_wr_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      fifo_full = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
      #1;
      chk1("full_ready", m_fifo_wr_ready, (c >= 1 && c <= 3) ? 1'b0 : 1'b1);
      chk4("full_en", fifo_wr_en, (c >= 1 && c <= 3) ? 4'b0000 : 4'b0100);
      chk1("full_busy", w_busy, 1'b1);
      chk1("full_nodone", w_done, 1'b0);
      step();
    end
    m_fifo_wr_en = 1'b0;
    #1;
    chk1("full_done", w_done, 1'b1);
    chk4("full_err", err_status, ee(4'b0001));
    step();

    // set event in the clear cycle wins
    err_clr = 1'b1; m_fifo_wr_en = 1'b1;
    step();
    err_clr = 1'b0; m_fifo_wr_en = 1'b0;
    #1;
    chk4("clr_set_wins", err_status, ee(4'b0001));
    clear_err();

    // concurrent read ch1 len0 and write ch3 len1
    r_start = 1'b1; r_active_channel = 2'd1; r_len = 8'd0;
    w_start = 1'b1; w_active_channel = 2'd3; w_len = 8'd1;
    step();
    r_start = 1'b0; w_start = 1'b0;
    m_fifo_rd_en = 1'b1; m_fifo_wr_en = 1'b1;
    #1;
    chk4("cc_rd_en", fifo_rd_en, 4'b0010);
    chk4("cc_wr_en1", fifo_wr_en, 4'b1000);
    chk1("cc_rd_valid", m_fifo_rd_valid, 1'b1);
    step();
    m_fifo_rd_en = 1'b0;
    #1;
    chk1("cc_r_done", r_done, 1'b1);
    chk1("cc_r_idle", r_busy, 1'b0);
    chk4("cc_rd_off", fifo_rd_en, 4'b0000);
    chk4("cc_wr_en2", fifo_wr_en, 4'b1000);
    chk1("cc_w_nodone", w_done, 1'b0);
    step();
    m_fifo_wr_en = 1'b0;
    #1;
    chk1("cc_w_done", w_done, 1'b1);
    chk1("cc_r_done_once", r_done, 1'b0);
    chk4("cc_err", err_status, 4'b0000);
    step();

    // start while busy is ignored: channel and count keep their values
    w_start = 1'b1; w_active_channel = 2'd1; w_len = 8'd1;
    step();
    w_active_channel = 2'd3; w_len = 8'd0;
    step();
    w_start = 1'b0; m_fifo_wr_en = 1'b1;
    #1;
    chk4("busy_start_ch", fifo_wr_en, 4'b0010);
    step();
    chk4("busy_start_cnt", fifo_wr_en, 4'b0010);
    chk1("busy_start_nodone", w_done, 1'b0);
    step();
    m_fifo_wr_en = 1'b0;
    #1;
    chk1("busy_start_done", w_done, 1'b1);
    chk4("busy_start_err", err_status, ee(4'b0100));
    clear_err();

    // back-to-back one-beat bursts, second start on the done cycle
    w_start = 1'b1; w_active_channel = 2'd0; w_len = 8'd0;
    step();
    w_start = 1'b0; m_fifo_wr_en = 1'b1;
    #1;
    chk4("b2b_first_en", fifo_wr_en, 4'b0001);
    step();
    m_fifo_wr_en = 1'b0; w_start = 1'b1; w_active_channel = 2'd1;
    #1;
    chk1("b2b_done1", w_done, 1'b1);
    step();
    w_start = 1'b0;
    #1;
    chk1("b2b_busy2", w_busy, 1'b1);
    chk1("b2b_done_once", w_done, 1'b0);
    m_fifo_wr_en = 1'b1;
    #1;
    chk4("b2b_second_en", fifo_wr_en, 4'b0010);
    step();
    m_fifo_wr_en = 1'b0;
    #1;
    chk1("b2b_done2", w_done, 1'b1);
    chk4("b2b_no_busy_err", err_status, 4'b0000);
    step();

    // all-ones length moves 256 beats
    w_start = 1'b1; w_active_channel = 2'd0; w_len = 8'hFF;
    step();
    w_start = 1'b0; m_fifo_wr_en = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      chk4("long_en", fifo_wr_en, 4'b0001);
      chk1("long_nodone", w_done, 1'b0);
      step();
    end
    m_fifo_wr_en = 1'b0;
    #1;
    chk1("long_done", w_done, 1'b1);
    chk1("long_idle", w_busy, 1'b0);
    step();

    // reset on beat 2 of an 8-beat read
    r_start = 1'b1; r_active_channel = 2'd0; r_len = 8'd7;
    step();
    r_start = 1'b0; m_fifo_rd_en = 1'b1;
    #1;
    chk4("rdrst_beat1", fifo_rd_en, 4'b0001);
    step();
    chk4("rdrst_beat2", fifo_rd_en, 4'b0001);
    ARESETn = 1'b0;
    #1;
    chk4("rdrst_rd_en", fifo_rd_en, 4'b0000);
    chk1("rdrst_valid", m_fifo_rd_valid, 1'b0);
    chk1("rdrst_busy", r_busy, 1'b0);
    chk1("rdrst_done", r_done, 1'b0);
    chk4("rdrst_err", err_status, 4'b0000);
    m_fifo_rd_en = 1'b0;
    step();
    step();
    ARESETn = 1'b1;
    step();
    chk1("rdrst_no_done", r_done, 1'b0);
    r_start = 1'b1; r_active_channel = 2'd2; r_len = 8'd0;
    step();
    r_start = 1'b0; m_fifo_rd_en = 1'b1; fifo_empty = 4'b0100;
    #1;
    chk1("rdempty_valid", m_fifo_rd_valid, 1'b0);
    chk4("rdempty_en", fifo_rd_en, 4'b0000);
    step();
    fifo_empty = 4'b0000;
    #1;
    chk1("rdnext_valid", m_fifo_rd_valid, 1'b1);
    chk4("rdnext_en", fifo_rd_en, 4'b0100);
    step();
    m_fifo_rd_en = 1'b0;
    #1;
    chk1("rdnext_done", r_done, 1'b1);
    chk4("rdnext_err", err_status, ee(4'b0010));
    clear_err();

    // three-channel instance: channel 3 is out of range
    d3_w_start = 1'b1; d3_w_ch = 2'd3;
    step();
    d3_w_start = 1'b0;
    #1;
    chk1("n3_busy", d3_w_busy, 1'b0);
    chk4("n3_wr_en", {1'b0, d3_fifo_wr_en}, 4'b0000);
    chk4("n3_err", d3_err_status, ee(4'b1000));
    step();
    chk1("n3_still_idle", d3_w_busy, 1'b0);
    d3_err_clr = 1'b1;
    step();
    d3_err_clr = 1'b0;
    #1;
    chk4("n3_err_clr", d3_err_status, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
